// File: rtl/vgg_fifo_pkg.sv
// rtl/vgg_fifo_pkg.sv - width helpers shared by the VGG16 streaming FIFOs
package vgg_fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A 2-entry FIFO still needs one pointer bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int entry_w(input int data_width, input int channel);
        return data_width * channel;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - FIFO pointer that wraps from DEPTH-1 to 0 (any DEPTH)
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_fwft_mc.sv
// rtl/fifo_fwft_mc.sv - multi-channel show-ahead FIFO; FIFO_ERR_FLAGS_EN enables sticky overflow/underflow
module fifo_fwft_mc
    import vgg_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CHANNEL    = 3,
    parameter  int DEPTH      = 8,
    parameter  int AFULL_TH   = 6,
    parameter  int AEMPTY_TH  = 2,
    localparam int W          = entry_w(DATA_WIDTH, CHANNEL),
    localparam int CNT_W      = cnt_w(DEPTH),
    localparam int PTR_W      = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [W-1:0]     data_in,
    input  logic             rd_req,
    output logic [W-1:0]     data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic [W-1:0]     mem [0:DEPTH-1];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] count_next;

    // A write at full is still accepted when the head is popped in the same cycle.
    assign wr_ok      = wr_req & (~full | rd_req);
    assign rd_ok      = rd_req & ~empty;
    assign count_next = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_ok),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_ok),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CNT_W'(DEPTH));
            almost_full  <= (count_next >= CNT_W'(AFULL_TH));
            almost_empty <= (count_next <= CNT_W'(AEMPTY_TH));
        end
    end

    // Head is read combinationally so it is visible the cycle after it is written.
    assign data_out = empty ? '0 : mem[rd_ptr];

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && !wr_ok) overflow  <= 1'b1;
            if (rd_req && empty)  underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_mc.sv
// tb/tb_fifo_fwft_mc.sv - randomized scoreboard bench for fifo_fwft_mc at DEPTH 8 and DEPTH 5
module tb_fifo_fwft_mc;

    localparam int WA = 96;
    localparam int WB = 16;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, wr_a = 1'b0, rd_a = 1'b0;
    logic [WA-1:0] din_a = '0, dout_a;
    logic          empty_a, full_a, af_a, ae_a, ovf_a, udf_a;
    logic [3:0]    count_a;

    logic          rst_b = 1'b1, wr_b = 1'b0, rd_b = 1'b0;
    logic [WB-1:0] din_b = '0, dout_b;
    logic          empty_b, full_b, af_b, ae_b, ovf_b, udf_b;
    logic [2:0]    count_b;

    fifo_fwft_mc #(.DATA_WIDTH(32), .CHANNEL(3), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut_a (
        .clk(clk), .rst(rst_a), .wr_req(wr_a), .data_in(din_a), .rd_req(rd_a),
        .data_out(dout_a), .empty(empty_a), .full(full_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a)
    );

    fifo_fwft_mc #(.DATA_WIDTH(8), .CHANNEL(2), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) dut_b (
        .clk(clk), .rst(rst_b), .wr_req(wr_b), .data_in(din_b), .rd_req(rd_b),
        .data_out(dout_b), .empty(empty_b), .full(full_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b)
    );

    int total = 0;
    int bad   = 0;

    logic [WA-1:0] qa[$];
    logic [WB-1:0] qb[$];
    bit ova = 1'b0, uda = 1'b0, ovb = 1'b0, udb = 1'b0;

    logic [9:0] stat_a;
    logic [8:0] stat_b;
    assign stat_a = {count_a, empty_a, full_a, af_a, ae_a, ovf_a, udf_a};
    assign stat_b = {count_b, empty_b, full_b, af_b, ae_b, ovf_b, udf_b};

    function automatic logic [9:0] exp_stat_a();
        int n = qa.size();
        return {4'(n), n == 0, n == 8, n >= 6, n <= 2, ova, uda};
    endfunction

    function automatic logic [8:0] exp_stat_b();
        int n = qb.size();
        return {3'(n), n == 0, n == 5, n >= 4, n <= 1, ovb, udb};
    endfunction

    function automatic logic [WA-1:0] exp_head_a();
        return (qa.size() > 0) ? qa[0] : '0;
    endfunction

    function automatic logic [WB-1:0] exp_head_b();
        return (qb.size() > 0) ? qb[0] : '0;
    endfunction

    function automatic logic [WA-1:0] rand_a();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle on FIFO A and advance the reference queue; outputs are sampled 1ns after the edge.
    task automatic cycle_a(input bit w, input bit r, input logic [WA-1:0] d, input bit rs);
        bit wok, rok;
        wr_a = w; rd_a = r; din_a = d; rst_a = rs;
        @(posedge clk);
        if (rs) begin
            qa.delete(); ova = 1'b0; uda = 1'b0;
        end else begin
            wok = w && (qa.size() < 8 || r);
            rok = r && (qa.size() > 0);
            if (w && !wok) ova |= ERR_EN;
            if (r && !rok) uda |= ERR_EN;
            if (rok) void'(qa.pop_front());
            if (wok) qa.push_back(d);
        end
        #1;
        wr_a = 1'b0; rd_a = 1'b0; rst_a = 1'b0;
    endtask

    task automatic cycle_b(input bit w, input bit r, input logic [WB-1:0] d, input bit rs);
        bit wok, rok;
        wr_b = w; rd_b = r; din_b = d; rst_b = rs;
        @(posedge clk);
        if (rs) begin
            qb.delete(); ovb = 1'b0; udb = 1'b0;
        end else begin
            wok = w && (qb.size() < 5 || r);
            rok = r && (qb.size() > 0);
            if (w && !wok) ovb |= ERR_EN;
            if (r && !rok) udb |= ERR_EN;
            if (rok) void'(qb.pop_front());
            if (wok) qb.push_back(d);
        end
        #1;
        wr_b = 1'b0; rd_b = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_reset();
        cycle_a(1'b0, 1'b0, '0, 1'b1);
        cycle_b(1'b0, 1'b0, '0, 1'b1);
        total++;
        if (stat_a !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_stat_a: got %b want 0000100100", stat_a);
        end
        total++;
        if (dout_a !== '0) begin bad++; $display("FAIL reset_data_a: got %h want 0", dout_a); end
        total++;
        if (stat_b !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_stat_b: got %b want 000100100", stat_b);
        end
        total++;
        if (dout_b !== '0) begin bad++; $display("FAIL reset_data_b: got %h want 0", dout_b); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle_a(1'b1, 1'b0, WA'(i), 1'b0);
            total++;
            if (count_a !== 4'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count_a, i); end
            total++;
            if (af_a !== (i >= 6)) begin bad++; $display("FAIL fill_afull: got %b want %b at push %0d", af_a, i >= 6, i); end
            total++;
            if (dout_a !== WA'(1)) begin bad++; $display("FAIL fill_head: got %h want 1", dout_a); end
        end
        total++;
        if (full_a !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full_a); end
        cycle_a(1'b1, 1'b0, WA'('hFF), 1'b0);
        total++;
        if (stat_a !== exp_stat_a()) begin bad++; $display("FAIL overflow_stat: got %b want %b", stat_a, exp_stat_a()); end
        total++;
        if (dout_a !== WA'(1)) begin bad++; $display("FAIL overflow_head: got %h want 1", dout_a); end
    endtask

    task automatic test_full_rw();
        cycle_a(1'b1, 1'b1, WA'(9), 1'b0);
        total++;
        if (count_a !== 4'd8 || full_a !== 1'b1) begin
            bad++; $display("FAIL full_rw_count: got count=%0d full=%b want 8/1", count_a, full_a);
        end
        total++;
        if (dout_a !== WA'(2)) begin bad++; $display("FAIL full_rw_head: got %h want 2", dout_a); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dout_a !== WA'(i + 2)) begin bad++; $display("FAIL drain_data: got %h want %h", dout_a, WA'(i + 2)); end
            cycle_a(1'b0, 1'b1, '0, 1'b0);
            total++;
            if (count_a !== 4'(7 - i) || ae_a !== ((7 - i) <= 2)) begin
                bad++; $display("FAIL drain_count: got count=%0d ae=%b want %0d/%b", count_a, ae_a, 7 - i, (7 - i) <= 2);
            end
        end
        total++;
        if (empty_a !== 1'b1 || dout_a !== '0) begin
            bad++; $display("FAIL drain_empty: got empty=%b data=%h want 1/0", empty_a, dout_a);
        end
    endtask

    task automatic test_empty_rw();
        cycle_a(1'b1, 1'b1, WA'('hA), 1'b0);
        total++;
        if (count_a !== 4'd1 || dout_a !== WA'('hA)) begin
            bad++; $display("FAIL empty_rw: got count=%0d data=%h want 1/a", count_a, dout_a);
        end
        total++;
        if (udf_a !== ERR_EN || ovf_a !== ERR_EN) begin
            bad++; $display("FAIL sticky_flags: got ovf=%b udf=%b want %b/%b", ovf_a, udf_a, ERR_EN, ERR_EN);
        end
        cycle_a(1'b0, 1'b1, '0, 1'b0);
        total++;
        if (stat_a !== exp_stat_a()) begin bad++; $display("FAIL empty_rw_pop: got %b want %b", stat_a, exp_stat_a()); end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 300; i++) begin
            cycle_a(($urandom() % 100) < 55, ($urandom() % 100) < 45, rand_a(), 1'b0);
            total++;
            if (stat_a !== exp_stat_a()) begin bad++; $display("FAIL rand_a_stat: cyc %0d got %b want %b", i, stat_a, exp_stat_a()); end
            total++;
            if (dout_a !== exp_head_a()) begin bad++; $display("FAIL rand_a_data: cyc %0d got %h want %h", i, dout_a, exp_head_a()); end
        end
    endtask

    task automatic test_wrap_b();
        for (int i = 0; i < 12; i++) begin
            cycle_b(i % 3 != 2, i % 3 == 2, WB'(16'h1100 + i), 1'b0);
            total++;
            if (stat_b !== exp_stat_b() || dout_b !== exp_head_b()) begin
                bad++; $display("FAIL wrap_b: step %0d got %b/%h want %b/%h", i, stat_b, dout_b, exp_stat_b(), exp_head_b());
            end
        end
        for (int i = 0; i < 200; i++) begin
            cycle_b(($urandom() % 100) < 60, ($urandom() % 100) < 50, WB'($urandom()), 1'b0);
            total++;
            if (stat_b !== exp_stat_b() || dout_b !== exp_head_b() || count_b > 3'd5) begin
                bad++; $display("FAIL rand_b: cyc %0d got %b/%h want %b/%h", i, stat_b, dout_b, exp_stat_b(), exp_head_b());
            end
        end
    endtask

    task automatic test_mid_reset();
        cycle_a(1'b0, 1'b0, '0, 1'b1);
        cycle_a(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 1'b0, rand_a(), 1'b0);
        total++;
        if (count_a !== 4'd4 || udf_a !== ERR_EN) begin
            bad++; $display("FAIL pre_reset: got count=%0d udf=%b want 4/%b", count_a, udf_a, ERR_EN);
        end
        cycle_a(1'b1, 1'b0, rand_a(), 1'b1);
        total++;
        if (stat_a !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0} || dout_a !== '0) begin
            bad++; $display("FAIL mid_reset: got %b/%h want 0000100100/0", stat_a, dout_a);
        end
        cycle_a(1'b0, 1'b0, '0, 1'b0);
        total++;
        if (empty_a !== 1'b1 || count_a !== 4'd0) begin
            bad++; $display("FAIL post_reset: got empty=%b count=%0d want 1/0", empty_a, count_a);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_empty_rw();
        test_random_a();
        test_wrap_b();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
